instr_fetch_decode: RTL and testbench
=====================================

// Module: instr_fetch_decode
// PURPOSE
//  Front end of the RV32I core: fetches one 32-bit instruction at a time from instruction memory,
//  decodes format, register indices and sign-extended immediate, and presents them to the
//  execute units (I_type, R_type, ...) through a valid/ready handshake.
//  Producer side of the idata/imm/rv-index bus consumed by the per-type instruction units.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC of the first fetch after reset release
// PORTS
//  clk            in   1   core clock; all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  imem_req       out  1   fetch request
//  imem_addr      out  32  fetch address (word aligned, [1:0]=0)
//  imem_gnt       in   1   memory accepts request this cycle (req & gnt = grant)
//  imem_rvalid    in   1   read data valid; exactly one per grant, >=1 cycle after grant
//  imem_rdata     in   32  instruction word
//  redirect_valid in   1   branch/jump taken: discard in-flight work, restart at redirect_pc
//  redirect_pc    in   32  new PC; bits [1:0] ignored (treated as 0)
//  dec_valid      out  1   decoded instruction available
//  dec_ready      in   1   consumer accepts (dec_valid & dec_ready = transfer)
//  dec_pc         out  32  PC of presented instruction
//  dec_idata      out  32  raw instruction word
//  dec_opcode     out  7   idata[6:0]
//  dec_rs1/rs2/rd out  5   idata[19:15] / [24:20] / [11:7]
//  dec_imm        out  32  sign-extended immediate per format
//  dec_illegal    out  1   opcode not in RV32I base set
// BEHAVIOUR
//  Reset: imem_req=0, dec_valid=0, all dec_* regs 0, pc=RESET_PC, state=IDLE.
//  Outputs registered; dec_* stable while dec_valid & !dec_ready.
//  One outstanding fetch max. FSM:
//   IDLE  1 cycle after reset release -> REQ.
//   REQ   imem_req=1, imem_addr=pc. grant -> WAIT. redirect w/o grant: pc<=redirect_pc, stay REQ
//         (addr changes next cycle). redirect with grant -> DROP, pc<=redirect_pc.
//   WAIT  rvalid -> capture + decode into dec_* regs, dec_valid=1 next cycle, pc<=pc+4, -> HOLD.
//         redirect (incl. same cycle as rvalid) -> response discarded, pc<=redirect_pc, -> DROP
//         (or -> REQ if rvalid coincides).
//   DROP  waits for stale rvalid, discards it, -> REQ. Further redirects only update pc.
//   HOLD  dec_valid=1. dec_ready -> dec_valid=0 next cycle, -> REQ.
//         redirect: dec_valid=0 next cycle, pc<=redirect_pc, -> REQ; if dec_ready same cycle the
//         transfer completes (consumer owns instr), redirect still applied.
//  Latency: rvalid at cycle m -> dec_valid at m+1; dec_ready at k -> imem_req at k+1.
//  Immediates (i=idata): I(0010011,0000011,1100111) {{20{i[31]}},i[31:20]};
//   S(0100011) {{20{i[31]}},i[31:25],i[11:7]}; B(1100011) {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0};
//   U(0110111,0010111) {i[31:12],12'b0}; J(1101111) {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0};
//   R(0110011) 0. Shift-imm: standard I imm, i[30] left in place for SRAI/SRLI select.
//  Illegal opcode (also 0001111/1110011 unsupported): dec_illegal=1, dec_imm=0, still presented.
//  pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
//  Async reset mid-operation: immediate return to reset values; a late rvalid after release is
//   ignored (FSM in IDLE/REQ without grant ignores rvalid).
// STRUCTURE
//  riscv_pkg: opcode_t enum (OP_IMM, OP, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC),
//   fetch_state_t enum {IDLE,REQ,WAIT,DROP,HOLD}, RESET_PC default constant.
//  Sub-module imm_gen (combinational: idata -> imm, illegal); FSM + regs in top.
// TESTING
//  Reset release, gnt=1, rvalid 1 cycle later -> imem_addr=0x0 first, then 0x4, 0x8 in order.
//  ADDI x1,x0,5 (0x00500093) -> opcode=0010011, rd=1, rs1=0, imm=0x00000005, illegal=0.
//  SRAI x1,x1,3 (0x4030D093) -> imm=0x00000403, idata[30]=1; BEQ x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC.
//  dec_ready low 5 cycles in HOLD -> dec_* stable, imem_req=0 throughout; ready -> req next cycle.
//  redirect to 0x100 in WAIT -> stale rvalid dropped, no dec_valid, next imem_addr=0x100.
//  rst_n low during WAIT, rvalid after release -> ignored, dec_valid=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the RV32I front end: base opcodes, fetch FSM states and
// the registered decode bundle handed to the execute units.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [6:0] {
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] idata;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  // Word-align an address; the low two bits of any fetch target are ignored.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: sign-extends the immediate for the
// instruction format implied by the opcode and flags opcodes outside the base set.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] idata,
  output logic [31:0] imm,
  output logic        illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch.
    imm     = '0;
    illegal = 1'b0;
    case (idata[6:0])
      OP_IMM, LOAD, JALR: imm = {{20{idata[31]}}, idata[31:20]};
      STORE:              imm = {{20{idata[31]}}, idata[31:25], idata[11:7]};
      BRANCH:             imm = {{19{idata[31]}}, idata[31], idata[7],
                                 idata[30:25], idata[11:8], 1'b0};
      LUI, AUIPC:         imm = {idata[31:12], 12'b0};
      JAL:                imm = {{11{idata[31]}}, idata[31], idata[19:12],
                                 idata[20], idata[30:21], 1'b0};
      OP:                 imm = '0;
      // FENCE and SYSTEM land here too: presented downstream as illegal.
      default:            illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// RV32I fetch/decode front end: one outstanding instruction fetch, decode into
// registered dec_* outputs, valid/ready hand-off and redirect handling.
module instr_fetch_decode
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_idata,
  output logic [6:0]  dec_opcode,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [4:0]  dec_rd,
  output logic [31:0] dec_imm,
  output logic        dec_illegal
);

  localparam logic [31:0] START_PC = word_align(RESET_PC);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_target;
  logic         grant;
  logic         capture;
  dec_t         dec_q;
  logic [31:0]  imm_w;
  logic         illegal_w;

  imm_gen u_imm_gen (
    .idata   (imem_rdata),
    .imm     (imm_w),
    .illegal (illegal_w)
  );

  assign redirect_target = word_align(redirect_pc);
  assign imem_req        = (state_q == REQ);
  assign imem_addr       = pc_q;
  assign grant           = imem_req & imem_gnt;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) pc_d = redirect_target;
      end
      REQ: begin
        // A redirect racing a grant leaves a response in flight that must be dropped.
        if (redirect_valid) begin
          pc_d = redirect_target;
          if (grant) state_d = DROP;
        end else if (grant) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          capture = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = HOLD;
        end
      end
      DROP: begin
        if (redirect_valid) pc_d = redirect_target;
        if (imem_rvalid) state_d = REQ;
      end
      HOLD: begin
        // With dec_ready in the same cycle the consumer already owns the instruction.
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = REQ;
        end else if (dec_ready) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= '0;
    end else if (capture) begin
      dec_q.pc      <= pc_q;
      dec_q.idata   <= imem_rdata;
      dec_q.imm     <= imm_w;
      dec_q.illegal <= illegal_w;
    end
  end

  assign dec_valid   = (state_q == HOLD);
  assign dec_pc      = dec_q.pc;
  assign dec_idata   = dec_q.idata;
  assign dec_opcode  = dec_q.idata[6:0];
  assign dec_rd      = dec_q.idata[11:7];
  assign dec_rs1     = dec_q.idata[19:15];
  assign dec_rs2     = dec_q.idata[24:20];
  assign dec_imm     = dec_q.imm;
  assign dec_illegal = dec_q.illegal;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: memory responder, architectural
// next-PC model with per-cycle compare, and directed scenarios with literal expectations.
module tb_instr_fetch_decode;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_idata;
  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [31:0] dec_imm;
  logic        dec_illegal;

  int checks = 0;
  int failures = 0;
  int vcount = 0;
  logic gnt_en;
  int   lat;
  logic [31:0] grant_log[$];
  logic [31:0] xfer_log[$];
  logic [31:0] q_addr[$];
  int          q_delay[$];

  instr_fetch_decode #(.RESET_PC(TB_RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_idata      (dec_idata),
    .dec_opcode     (dec_opcode),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .dec_imm        (dec_imm),
    .dec_illegal    (dec_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Instruction memory image; unlisted words are ADDI x1,x0,addr[11:0].
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00: return 32'h00500093;
      32'h04: return 32'h4030D093;
      32'h08: return 32'hFE000EE3;
      32'h0C: return 32'h0000000F;
      32'h10: return 32'h123450B7;
      32'h14: return 32'hFE20AC23;
      32'h18: return 32'h008000EF;
      32'h1C: return 32'h002081B3;
      default: return ((a & 32'hFFF) << 20) | 32'h00000093;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic [31:0] sx;
    sx = (w >> 31) != 0 ? 32'hFFFF_FFFF : 32'h0;
    case (w & 32'h7F)
      32'h13, 32'h03, 32'h67: return (sx << 12) | (w >> 20);
      32'h23: return (sx << 12) | ((w >> 25) << 5) | ((w >> 7) & 32'h1F);
      32'h63: return (sx << 12) | (((w >> 7) & 32'h1) << 11)
                   | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
      32'h37, 32'h17: return w & 32'hFFFF_F000;
      32'h6F: return (sx << 20) | (w & 32'h000F_F000)
                   | (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] w);
    case (w & 32'h7F)
      32'h13, 32'h33, 32'h03, 32'h23, 32'h63, 32'h6F, 32'h67, 32'h37, 32'h17: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Memory responder: grants per gnt_en, answers each grant after lat cycles.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (q_addr.size() > 0) begin
        if (q_delay[0] == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(q_addr[0]);
          void'(q_addr.pop_front());
          void'(q_delay.pop_front());
        end else begin
          q_delay[0] = q_delay[0] - 1;
        end
      end
      imem_gnt = gnt_en;
      if (rst_n && imem_req && imem_gnt) begin
        q_addr.push_back(imem_addr);
        q_delay.push_back(lat - 1);
        grant_log.push_back(imem_addr);
      end
    end
  end

  // Model: the next instruction presented is the redirect target after a redirect,
  // the sequential successor after a transfer, and RESET_PC after reset.
  initial begin
    logic [31:0] exp_pc, w, ppc, pid, pimm;
    logic pv, pr, prd, prst, pill;
    exp_pc = TB_RESET_PC;
    pv = 1'b0; pr = 1'b0; prd = 1'b0; prst = 1'b0; pill = 1'b0;
    ppc = '0; pid = '0; pimm = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && dec_valid) begin
        vcount++;
        w = mem_word(exp_pc);
        check("cmp_pc", dec_pc, exp_pc);
        check("cmp_idata", dec_idata, w);
        check("cmp_opcode", dec_opcode, w & 32'h7F);
        check("cmp_rd", dec_rd, (w >> 7) & 32'h1F);
        check("cmp_rs1", dec_rs1, (w >> 15) & 32'h1F);
        check("cmp_rs2", dec_rs2, (w >> 20) & 32'h1F);
        check("cmp_imm", dec_imm, ref_imm(w));
        check("cmp_illegal", dec_illegal, ref_illegal(w));
      end
      if (rst_n && prst && pv && !pr && !prd) begin
        check("stable_valid", dec_valid, 1'b1);
        check("stable_pc", dec_pc, ppc);
        check("stable_idata", dec_idata, pid);
        check("stable_imm", dec_imm, pimm);
        check("stable_illegal", dec_illegal, pill);
      end
      if (rst_n && imem_req) check("addr_align", imem_addr & 32'h3, 32'h0);
      if (rst_n && dec_valid && dec_ready) xfer_log.push_back(dec_pc);
      if (!rst_n) exp_pc = TB_RESET_PC;
      else if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (dec_valid && dec_ready) exp_pc = exp_pc + 32'd4;
      pv = dec_valid; pr = dec_ready; prd = redirect_valid; prst = rst_n;
      ppc = dec_pc; pid = dec_idata; pimm = dec_imm; pill = dec_illegal;
    end
  end

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dec_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_arrived"}, 32'(ok), 32'h1);
  endtask

  task automatic wait_req(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_req"}, 32'(ok), 32'h1);
  endtask

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] word,
                              input logic [31:0] imm, input logic ill, input string name);
    wait_valid(name);
    check({name, "_pc"}, dec_pc, pc);
    check({name, "_idata"}, dec_idata, word);
    check({name, "_imm"}, dec_imm, imm);
    check({name, "_illegal"}, dec_illegal, ill);
  endtask

  initial begin
    int vsnap;
    rst_n = 1'b0; gnt_en = 1'b1; lat = 1;
    dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", dec_valid, 1'b0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_idata", dec_idata, 32'h0);
    check("rst_imm", dec_imm, 32'h0);
    check("rst_illegal", dec_illegal, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 32'h0);

    expect_instr(32'h0, 32'h00500093, 32'h5, 1'b0, "addi");
    check("addi_opcode", dec_opcode, 7'b0010011);
    check("addi_rd", dec_rd, 5'd1);
    check("addi_rs1", dec_rs1, 5'd0);
    expect_instr(32'h4, 32'h4030D093, 32'h403, 1'b0, "srai");
    check("srai_bit30", dec_idata[30], 1'b1);
    @(negedge clk);
    dec_ready = 1'b0;
    expect_instr(32'h8, 32'hFE000EE3, 32'hFFFF_FFFC, 1'b0, "beq");
    for (int i = 0; i < 5; i++) begin
      check("hold_no_req", imem_req, 1'b0);
      check("hold_valid", dec_valid, 1'b1);
      check("hold_imm", dec_imm, 32'hFFFF_FFFC);
      @(negedge clk);
    end
    dec_ready = 1'b1;
    @(negedge clk);
    check("release_valid", dec_valid, 1'b0);
    check("release_req", imem_req, 1'b1);
    check("release_addr", imem_addr, 32'hC);
    check("grant_count", 32'(grant_log.size() >= 3), 32'h1);
    if (grant_log.size() >= 3) begin
      check("grant0", grant_log[0], 32'h0);
      check("grant1", grant_log[1], 32'h4);
      check("grant2", grant_log[2], 32'h8);
    end

    expect_instr(32'hC, 32'h0000000F, 32'h0, 1'b1, "fence");
    expect_instr(32'h10, 32'h123450B7, 32'h1234_5000, 1'b0, "lui");
    expect_instr(32'h14, 32'hFE20AC23, 32'hFFFF_FFF8, 1'b0, "sw");
    check("sw_rs1", dec_rs1, 5'd1);
    check("sw_rs2", dec_rs2, 5'd2);
    expect_instr(32'h18, 32'h008000EF, 32'h8, 1'b0, "jal");
    lat = 4;
    expect_instr(32'h1C, 32'h002081B3, 32'h0, 1'b0, "add");
    check("add_rd", dec_rd, 5'd3);

    // Redirect while waiting for the response: the stale word must not surface.
    wait_req("drop");
    check("drop_fetch_addr", imem_addr, 32'h20);
    @(negedge clk);
    check("drop_in_wait", imem_req, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h103; vsnap = vcount;
    @(negedge clk);
    redirect_valid = 1'b0; lat = 1;
    wait_req("drop_restart");
    check("drop_new_addr", imem_addr, 32'h100);
    check("drop_no_valid", vcount, vsnap);
    expect_instr(32'h100, 32'h10000093, 32'h100, 1'b0, "redir");

    // Redirect in the same cycle as the response.
    lat = 2;
    wait_req("coinc");
    check("coinc_fetch_addr", imem_addr, 32'h104);
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h400; vsnap = vcount;
    @(negedge clk);
    redirect_valid = 1'b0; gnt_en = 1'b0; lat = 1;
    check("coinc_valid", dec_valid, 1'b0);
    check("coinc_req", imem_req, 1'b1);
    check("coinc_addr", imem_addr, 32'h400);
    check("coinc_no_valid", vcount, vsnap);

    // Redirect while requesting without a grant: address follows next cycle.
    @(negedge clk);
    check("nogrant_addr", imem_addr, 32'h400);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("nogrant_req", imem_req, 1'b1);
    check("nogrant_new_addr", imem_addr, 32'h200);
    gnt_en = 1'b1;
    expect_instr(32'h200, 32'h20000093, 32'h200, 1'b0, "reqredir");
    check("reqredir_grant", grant_log[grant_log.size() - 1], 32'h200);

    // Redirect together with dec_ready in HOLD: transfer completes, fetch moves.
    expect_instr(32'h204, 32'h20400093, 32'h204, 1'b0, "holdredir");
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("holdredir_valid", dec_valid, 1'b0);
    check("holdredir_req", imem_req, 1'b1);
    check("holdredir_addr", imem_addr, 32'hFFFF_FFFC);
    check("holdredir_xfer", xfer_log[xfer_log.size() - 1], 32'h204);
    expect_instr(32'hFFFF_FFFC, 32'hFFC00093, 32'hFFFF_FFFC, 1'b0, "top");
    wait_req("wrap");
    check("wrap_addr", imem_addr, 32'h0);
    expect_instr(32'h0, 32'h00500093, 32'h5, 1'b0, "addi_again");

    // Reset during WAIT; the late response after release must be ignored.
    lat = 6;
    wait_req("rstwait");
    check("rstwait_addr", imem_addr, 32'h4);
    @(negedge clk);
    check("rstwait_in_wait", imem_req, 1'b0);
    gnt_en = 1'b0; rst_n = 1'b0; vsnap = vcount;
    #1;
    check("async_rst_req", imem_req, 1'b0);
    check("async_rst_valid", dec_valid, 1'b0);
    check("async_rst_idata", dec_idata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (q_addr.size() == 0) break;
    end
    @(negedge clk);
    check("late_rvalid_drained", 32'(q_addr.size()), 32'h0);
    check("late_rvalid_ignored", vcount, vsnap);
    check("late_valid", dec_valid, 1'b0);
    check("restart_req", imem_req, 1'b1);
    check("restart_addr", imem_addr, TB_RESET_PC);
    gnt_en = 1'b1; lat = 1;
    expect_instr(32'h0, 32'h00500093, 32'h5, 1'b0, "after_rst");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
